// File: rtl/host_trans_controller_if.sv
// ---------------------------------------------------------------------------
// host_trans_controller_if
// Groups the host transaction controller's handshake and status signals.
//   Requests   : transReq, transType[1:0], SOFReq, isoEn
//   Sender     : sendPacketRdy (in), sendPacketWEn / sendPacketPID[3:0] (out)
//   Receiver   : getPacketRdy, RxPID[3:0], CRCError, bitStuffError,
//                RxOverflow, RxTimeOut (in), getPacketREn (out)
//   Status     : transDone, HCStatus[7:0], busy (out)
// slave  : controller side (consumes requests, produces strobes/status)
// master : host/environment side
// ---------------------------------------------------------------------------
interface host_trans_controller_if;
    logic       transReq;
    logic [1:0] transType;
    logic       SOFReq;
    logic       isoEn;
    logic       sendPacketRdy;
    logic       getPacketRdy;
    logic [3:0] RxPID;
    logic       CRCError;
    logic       bitStuffError;
    logic       RxOverflow;
    logic       RxTimeOut;
    logic       sendPacketWEn;
    logic [3:0] sendPacketPID;
    logic       getPacketREn;
    logic       transDone;
    logic [7:0] HCStatus;
    logic       busy;

    modport slave (
        input  transReq, transType, SOFReq, isoEn,
        input  sendPacketRdy, getPacketRdy, RxPID,
        input  CRCError, bitStuffError, RxOverflow, RxTimeOut,
        output sendPacketWEn, sendPacketPID, getPacketREn,
        output transDone, HCStatus, busy
    );

    modport master (
        output transReq, transType, SOFReq, isoEn,
        output sendPacketRdy, getPacketRdy, RxPID,
        output CRCError, bitStuffError, RxOverflow, RxTimeOut,
        input  sendPacketWEn, sendPacketPID, getPacketREn,
        input  transDone, HCStatus, busy
    );
endinterface

// File: rtl/host_trans_controller.sv
// ---------------------------------------------------------------------------
// host_trans_controller
// USB host transaction sequencer: issues a token (SOF/SETUP/IN/OUT), then a
// data packet or a data receive, then a handshake receive or ACK send, and
// reports the outcome in HCStatus with a one-cycle transDone pulse.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-low reset
//   bus  : host_trans_controller_if.slave (requests, packet sender/receiver
//          handshakes, status outputs)
// All outputs are registered; strobes are derived from the next state so a
// strobe is visible for exactly the one cycle spent in its issuing state.
// ---------------------------------------------------------------------------
module host_trans_controller (
    input  logic                        clk,
    input  logic                        rst,
    host_trans_controller_if.slave      bus
);

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_TOKEN        = 4'd1,
        ST_TOKEN_WAIT   = 4'd2,
        ST_DATA_TX      = 4'd3,
        ST_DATA_TX_WAIT = 4'd4,
        ST_HS_RX        = 4'd5,
        ST_HS_RX_WAIT   = 4'd6,
        ST_DATA_RX      = 4'd7,
        ST_DATA_RX_WAIT = 4'd8,
        ST_ACK_TX       = 4'd9,
        ST_ACK_TX_WAIT  = 4'd10,
        ST_DONE         = 4'd11
    } state_t;

    localparam logic [1:0] TYPE_SETUP = 2'd0;
    localparam logic [1:0] TYPE_IN    = 2'd1;
    localparam logic [1:0] TYPE_OUT1  = 2'd3;

    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    // Token PID for a non-SOF transaction of the given type.
    function automatic logic [3:0] token_pid(input logic [1:0] ttype);
        logic [3:0] pid;
        case (ttype)
            TYPE_SETUP: pid = PID_SETUP;
            TYPE_IN:    pid = PID_IN;
            default:    pid = PID_OUT;
        endcase
        return pid;
    endfunction

    // Data PID for an outgoing data packet; only OUT_DATA1 uses DATA1.
    function automatic logic [3:0] data_pid(input logic [1:0] ttype);
        logic [3:0] pid;
        if (ttype == TYPE_OUT1) begin
            pid = PID_DATA1;
        end else begin
            pid = PID_DATA0;
        end
        return pid;
    endfunction

    state_t     state_r;
    state_t     state_s;
    logic [1:0] trans_type_r;
    logic [1:0] trans_type_s;
    logic       iso_en_r;
    logic       iso_en_s;
    logic       sof_r;
    logic       sof_s;
    logic [3:0] send_pid_r;
    logic [3:0] send_pid_s;
    logic [7:0] hc_status_r;
    logic [7:0] hc_status_s;
    logic       send_wen_r;
    logic       get_ren_r;
    logic       trans_done_r;
    logic       busy_r;
    logic       send_wen_s;
    logic       get_ren_s;
    logic       trans_done_s;
    logic       busy_s;
    logic [3:0] rx_flags_s;
    logic       rx_err_s;

    assign rx_flags_s = {bus.RxTimeOut, bus.RxOverflow, bus.bitStuffError, bus.CRCError};
    assign rx_err_s   = |rx_flags_s;

    // Next-state, latched-context and status computation.
    always_comb begin
        state_s      = state_r;
        trans_type_s = trans_type_r;
        iso_en_s     = iso_en_r;
        sof_s        = sof_r;
        send_pid_s   = send_pid_r;
        hc_status_s  = hc_status_r;

        case (state_r)
            ST_IDLE: begin
                // SOF has priority; HCStatus is left alone for SOF.
                if (bus.SOFReq) begin
                    sof_s      = 1'b1;
                    send_pid_s = PID_SOF;
                    state_s    = ST_TOKEN;
                end else if (bus.transReq) begin
                    sof_s        = 1'b0;
                    trans_type_s = bus.transType;
                    iso_en_s     = bus.isoEn;
                    hc_status_s  = 8'h00;
                    send_pid_s   = token_pid(bus.transType);
                    state_s      = ST_TOKEN;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_TOKEN: begin
                state_s = ST_TOKEN_WAIT;
            end

            ST_TOKEN_WAIT: begin
                if (bus.sendPacketRdy) begin
                    if (sof_r) begin
                        state_s = ST_DONE;
                    end else if (trans_type_r == TYPE_IN) begin
                        state_s = ST_DATA_RX;
                    end else begin
                        send_pid_s = data_pid(trans_type_r);
                        state_s    = ST_DATA_TX;
                    end
                end else begin
                    state_s = ST_TOKEN_WAIT;
                end
            end

            ST_DATA_TX: begin
                state_s = ST_DATA_TX_WAIT;
            end

            ST_DATA_TX_WAIT: begin
                if (bus.sendPacketRdy) begin
                    if (iso_en_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_HS_RX;
                    end
                end else begin
                    state_s = ST_DATA_TX_WAIT;
                end
            end

            ST_HS_RX: begin
                state_s = ST_HS_RX_WAIT;
            end

            ST_HS_RX_WAIT: begin
                if (bus.getPacketRdy) begin
                    hc_status_s[3:0] = rx_flags_s;
                    // Any receive error suppresses the handshake flags.
                    if (!rx_err_s) begin
                        case (bus.RxPID)
                            PID_ACK:   hc_status_s[6] = 1'b1;
                            PID_NAK:   hc_status_s[4] = 1'b1;
                            PID_STALL: hc_status_s[5] = 1'b1;
                            default:   hc_status_s[6:4] = hc_status_r[6:4];
                        endcase
                    end else begin
                        hc_status_s[7:4] = hc_status_r[7:4];
                    end
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_HS_RX_WAIT;
                end
            end

            ST_DATA_RX: begin
                state_s = ST_DATA_RX_WAIT;
            end

            ST_DATA_RX_WAIT: begin
                if (bus.getPacketRdy) begin
                    hc_status_s[3:0] = rx_flags_s;
                    if (!rx_err_s && (bus.RxPID == PID_DATA0 || bus.RxPID == PID_DATA1)) begin
                        hc_status_s[7] = (bus.RxPID == PID_DATA1);
                        if (iso_en_r) begin
                            state_s = ST_DONE;
                        end else begin
                            send_pid_s = PID_ACK;
                            state_s    = ST_ACK_TX;
                        end
                    end else if (!rx_err_s && bus.RxPID == PID_NAK) begin
                        hc_status_s[4] = 1'b1;
                        state_s        = ST_DONE;
                    end else if (!rx_err_s && bus.RxPID == PID_STALL) begin
                        hc_status_s[5] = 1'b1;
                        state_s        = ST_DONE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_DATA_RX_WAIT;
                end
            end

            ST_ACK_TX: begin
                state_s = ST_ACK_TX_WAIT;
            end

            ST_ACK_TX_WAIT: begin
                if (bus.sendPacketRdy) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ACK_TX_WAIT;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output strobes follow the state being entered so they register cleanly.
    always_comb begin
        send_wen_s   = (state_s == ST_TOKEN) || (state_s == ST_DATA_TX) || (state_s == ST_ACK_TX);
        get_ren_s    = (state_s == ST_HS_RX) || (state_s == ST_DATA_RX);
        trans_done_s = (state_s == ST_DONE);
        busy_s       = (state_s != ST_IDLE);
    end

    // State, context and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            trans_type_r <= 2'd0;
            iso_en_r     <= 1'b0;
            sof_r        <= 1'b0;
            send_pid_r   <= 4'h0;
            hc_status_r  <= 8'h00;
            send_wen_r   <= 1'b0;
            get_ren_r    <= 1'b0;
            trans_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            trans_type_r <= trans_type_s;
            iso_en_r     <= iso_en_s;
            sof_r        <= sof_s;
            send_pid_r   <= send_pid_s;
            hc_status_r  <= hc_status_s;
            send_wen_r   <= send_wen_s;
            get_ren_r    <= get_ren_s;
            trans_done_r <= trans_done_s;
            busy_r       <= busy_s;
        end
    end

    assign bus.sendPacketWEn = send_wen_r;
    assign bus.sendPacketPID = send_pid_r;
    assign bus.getPacketREn  = get_ren_r;
    assign bus.transDone     = trans_done_r;
    assign bus.HCStatus      = hc_status_r;
    assign bus.busy          = busy_r;

endmodule

// File: tb/tb_host_trans_controller.sv
// ---------------------------------------------------------------------------
// tb_host_trans_controller
// Scoreboard bench: expected send PIDs and completion status are queued when
// a transaction is started and checked as the controller emits strobes and
// transDone. Simple sender/receiver responders run inside the step task.
// ---------------------------------------------------------------------------
module tb_host_trans_controller;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    host_trans_controller_if bus();

    host_trans_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_pid_q[$];
    logic [7:0] exp_stat_q[$];
    int         rx_strobes  = 0;
    int         done_cnt    = 0;
    int         busy_cycles = 0;
    int         send_wait   = 0;
    int         rx_wait     = 0;
    int         send_cnt    = 0;
    int         rx_cnt      = 0;
    logic [3:0] rsp_pid     = 4'h0;
    logic [3:0] rsp_err     = 4'h0;
    logic [7:0] last_stat   = 8'h00;

    // Advance one cycle, check outputs against the scoreboard, run responders.
    task automatic step();
        logic [3:0] ep;
        logic [7:0] es;
        @(posedge clk);
        #1;
        if (bus.busy === 1'b1) busy_cycles++;
        if (bus.sendPacketWEn === 1'b1) begin
            n_vec++;
            if (exp_pid_q.size() == 0) begin
                n_err++;
                $display("FAIL send_strobe: got unexpected PID %h, required no strobe", bus.sendPacketPID);
            end else begin
                ep = exp_pid_q.pop_front();
                if (bus.sendPacketPID !== ep) begin
                    n_err++;
                    $display("FAIL send_pid: got %h, required %h", bus.sendPacketPID, ep);
                end
            end
        end
        if (bus.getPacketREn === 1'b1) rx_strobes++;
        if (bus.transDone === 1'b1) begin
            done_cnt++;
            n_vec++;
            if (exp_stat_q.size() == 0) begin
                n_err++;
                $display("FAIL trans_done: got unexpected pulse, required none");
            end else begin
                es = exp_stat_q.pop_front();
                if (bus.HCStatus !== es) begin
                    n_err++;
                    $display("FAIL hc_status: got %h, required %h", bus.HCStatus, es);
                end
            end
        end
        // receiver responder
        if (bus.getPacketRdy === 1'b1) begin
            bus.getPacketRdy = 1'b0;
            bus.RxPID = 4'h0;
            {bus.RxTimeOut, bus.RxOverflow, bus.bitStuffError, bus.CRCError} = 4'h0;
        end
        if (bus.getPacketREn === 1'b1) begin
            rx_cnt = rx_wait + 1;
        end else if (rx_cnt > 0) begin
            rx_cnt--;
            if (rx_cnt == 0) begin
                bus.getPacketRdy = 1'b1;
                bus.RxPID = rsp_pid;
                {bus.RxTimeOut, bus.RxOverflow, bus.bitStuffError, bus.CRCError} = rsp_err;
            end
        end
        // sender responder
        if (bus.sendPacketWEn === 1'b1) begin
            send_cnt = send_wait;
            if (send_wait > 0) bus.sendPacketRdy = 1'b0;
        end else if (send_cnt > 0) begin
            send_cnt--;
            if (send_cnt == 0) bus.sendPacketRdy = 1'b1;
        end
    endtask

    // Present a request for one cycle so the controller samples it in IDLE.
    task automatic start(input logic sof, input logic req, input logic [1:0] ttype, input logic iso);
        bus.SOFReq    = sof;
        bus.transReq  = req;
        bus.transType = ttype;
        bus.isoEn     = iso;
        step();
        bus.SOFReq   = 1'b0;
        bus.transReq = 1'b0;
    endtask

    // Step until transDone (bounded), then into IDLE; check nothing is left queued.
    task automatic run_trans(input string name);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < 300) begin
            step();
            k++;
        end
        n_vec++;
        if (done_cnt == d0) begin
            n_err++;
            $display("FAIL %s_timeout: got no transDone in 300 cycles, required one", name);
        end
        step();
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle_busy: got %b, required 0", name, bus.busy);
        end
        n_vec++;
        if (exp_pid_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing_strobes: got %0d unsent, required 0", name, exp_pid_q.size());
        end
        exp_pid_q.delete();
        exp_stat_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.transReq = 1'b0; bus.transType = 2'd0; bus.SOFReq = 1'b0; bus.isoEn = 1'b0;
        bus.sendPacketRdy = 1'b1; bus.getPacketRdy = 1'b0; bus.RxPID = 4'h0;
        bus.CRCError = 1'b0; bus.bitStuffError = 1'b0; bus.RxOverflow = 1'b0; bus.RxTimeOut = 1'b0;
        step();
        step();
        n_vec++;
        if ({bus.sendPacketWEn, bus.getPacketREn, bus.transDone, bus.busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_strobes: got wen/ren/done/busy=%b, required 0000",
                     {bus.sendPacketWEn, bus.getPacketREn, bus.transDone, bus.busy});
        end
        n_vec++;
        if (bus.sendPacketPID !== 4'h0) begin
            n_err++;
            $display("FAIL reset_pid: got %h, required 0", bus.sendPacketPID);
        end
        n_vec++;
        if (bus.HCStatus !== 8'h00) begin
            n_err++;
            $display("FAIL reset_status: got %h, required 00", bus.HCStatus);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_out_data1();
        int r0;
        send_wait = 0; rx_wait = 0;
        rsp_pid = 4'h2; rsp_err = 4'h0;
        exp_pid_q.push_back(4'h1); exp_pid_q.push_back(4'hB);
        exp_stat_q.push_back(8'h40); last_stat = 8'h40;
        r0 = rx_strobes; busy_cycles = 0;
        start(1'b0, 1'b1, 2'd3, 1'b0);
        run_trans("out_data1");
        n_vec++;
        if (rx_strobes - r0 != 1) begin
            n_err++;
            $display("FAIL out_data1_rx_strobes: got %0d, required 1", rx_strobes - r0);
        end
        // accept -> TOKEN, TOKEN_WAIT, DATA_TX, DATA_TX_WAIT, HS_RX, HS_RX_WAIT, DONE
        n_vec++;
        if (busy_cycles != 7) begin
            n_err++;
            $display("FAIL out_min_latency: got %0d busy cycles, required 7", busy_cycles);
        end
    endtask

    task automatic test_in_ack();
        int r0;
        send_wait = 2; rx_wait = 1;
        rsp_pid = 4'hB; rsp_err = 4'h0;
        exp_pid_q.push_back(4'h9); exp_pid_q.push_back(4'h2);
        exp_stat_q.push_back(8'h80); last_stat = 8'h80;
        r0 = rx_strobes;
        start(1'b0, 1'b1, 2'd1, 1'b0);
        // mid-transaction request/context changes must be ignored
        bus.transType = 2'd0; bus.isoEn = 1'b1; bus.transReq = 1'b1;
        step();
        step();
        bus.transReq = 1'b0;
        run_trans("in_ack");
        n_vec++;
        if (rx_strobes - r0 != 1) begin
            n_err++;
            $display("FAIL in_ack_rx_strobes: got %0d, required 1", rx_strobes - r0);
        end
        send_wait = 0; rx_wait = 0;
    endtask

    task automatic test_sof_priority();
        int d0;
        exp_pid_q.push_back(4'h5);
        exp_stat_q.push_back(last_stat);
        start(1'b1, 1'b1, 2'd2, 1'b0);
        run_trans("sof");
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) step();
        n_vec++;
        if (done_cnt != d0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL sof_no_queue: got %0d extra done busy=%b, required 0 and 0", done_cnt - d0, bus.busy);
        end
    endtask

    task automatic test_setup_iso();
        int r0;
        exp_pid_q.push_back(4'hD); exp_pid_q.push_back(4'h3);
        exp_stat_q.push_back(8'h00); last_stat = 8'h00;
        r0 = rx_strobes;
        start(1'b0, 1'b1, 2'd0, 1'b1);
        run_trans("setup_iso");
        n_vec++;
        if (rx_strobes != r0) begin
            n_err++;
            $display("FAIL setup_iso_rx_strobes: got %0d, required 0", rx_strobes - r0);
        end
    endtask

    task automatic test_in_errors();
        logic [1:0] ty  [6] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1};
        logic [3:0] pid [6] = '{4'h3, 4'hA, 4'hB, 4'hE, 4'h2, 4'h3};
        logic [3:0] err [6] = '{4'h1, 4'h0, 4'h8, 4'h0, 4'h2, 4'h0};
        logic [7:0] st  [6] = '{8'h01, 8'h10, 8'h08, 8'h20, 8'h02, 8'h00};
        logic [3:0] tok [6] = '{4'h9, 4'h9, 4'h9, 4'h1, 4'h1, 4'h9};
        logic [3:0] sec [6] = '{4'h0, 4'h0, 4'h0, 4'h3, 4'h3, 4'h2};
        logic       has2[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int r0;
        for (int i = 0; i < 6; i++) begin
            rsp_pid = pid[i]; rsp_err = err[i];
            exp_pid_q.push_back(tok[i]);
            if (has2[i]) exp_pid_q.push_back(sec[i]);
            exp_stat_q.push_back(st[i]); last_stat = st[i];
            r0 = rx_strobes;
            start(1'b0, 1'b1, ty[i], 1'b0);
            run_trans("rx_case");
            n_vec++;
            if (rx_strobes - r0 != 1) begin
                n_err++;
                $display("FAIL rx_case%0d_rx_strobes: got %0d, required 1", i, rx_strobes - r0);
            end
        end
    endtask

    task automatic test_back_to_back();
        rsp_pid = 4'h3; rsp_err = 4'h0;
        exp_pid_q.push_back(4'h9);
        exp_stat_q.push_back(8'h00);
        start(1'b0, 1'b1, 2'd1, 1'b1);
        run_trans("b2b_iso_in");
        send_wait = 3; rx_wait = 2;
        rsp_pid = 4'h2;
        exp_pid_q.push_back(4'h1); exp_pid_q.push_back(4'h3);
        exp_stat_q.push_back(8'h40); last_stat = 8'h40;
        start(1'b0, 1'b1, 2'd2, 1'b0);
        run_trans("b2b_out0");
        send_wait = 0; rx_wait = 0;
    endtask

    task automatic test_reset_mid();
        int k;
        int d0;
        send_wait = 4;
        exp_pid_q.push_back(4'hD); exp_pid_q.push_back(4'h3);
        start(1'b0, 1'b1, 2'd0, 1'b1);
        k = 0;
        while (exp_pid_q.size() != 0 && k < 50) begin
            step();
            k++;
        end
        n_vec++;
        if (exp_pid_q.size() != 0) begin
            n_err++;
            $display("FAIL rst_mid_setup: got %0d strobes missing, required 0", exp_pid_q.size());
        end
        step();
        rst = 1'b0;
        d0 = done_cnt;
        step();
        n_vec++;
        if ({bus.sendPacketWEn, bus.getPacketREn, bus.transDone, bus.busy, bus.sendPacketPID, bus.HCStatus} !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got wen/ren/done/busy=%b pid=%h st=%h, required all 0",
                     {bus.sendPacketWEn, bus.getPacketREn, bus.transDone, bus.busy}, bus.sendPacketPID, bus.HCStatus);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step();
        n_vec++;
        if (done_cnt != d0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_quiet: got %0d done busy=%b, required 0 and 0", done_cnt - d0, bus.busy);
        end
        send_wait = 0;
    endtask

    initial begin
        test_reset();
        test_out_data1();
        test_in_ack();
        test_sof_priority();
        test_setup_iso();
        test_in_errors();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/host_trans_controller.md
HOST_TRANS_CONTROLLER -- requirements
Module: host_trans_controller

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-003 SHALL have port: transReq  in  1  start transaction; sampled only in IDLE.
REQ-004 SHALL have port: transType  in  2  0=SETUP, 1=IN, 2=OUT_DATA0, 3=OUT_DATA1.
REQ-005 SHALL have port: SOFReq  in  1  send SOF token; sampled only in IDLE.
REQ-006 SHALL have port: isoEn  in  1  isochronous; no handshake phase.
REQ-007 SHALL have port: sendPacketRdy  in  1  packet sender idle/finished.
REQ-008 SHALL have port: getPacketRdy  in  1  packet receiver finished.
REQ-009 SHALL have port: RxPID  in  4  PID of last received packet; valid with getPacketRdy.
REQ-010 SHALL have port: CRCError, bitStuffError, RxOverflow, RxTimeOut  in  1 each  receiver error flags; valid with getPacketRdy.
REQ-011 SHALL have port: sendPacketWEn  out  1  one-cycle send strobe.
REQ-012 SHALL have port: sendPacketPID  out  4  PID to send; held until next strobe.
REQ-013 SHALL have port: getPacketREn  out  1  one-cycle receive strobe.
REQ-014 SHALL have port: transDone  out  1  one-cycle completion pulse.
REQ-015 SHALL have port: HCStatus  out  8  [0]CRCError [1]bitStuffError [2]RxOverflow [3]RxTimeOut [4]NAKRxed [5]stallRxed [6]ACKRxed [7]dataSequence.
REQ-016 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, TOKEN, TOKEN_WAIT, DATA_TX, DATA_TX_WAIT, HS_RX, HS_RX_WAIT, DATA_RX, DATA_RX_WAIT, ACK_TX, ACK_TX_WAIT, DONE; all outputs registered.
REQ-018 IDLE: SOFReq=1 SHALL win over transReq; next cycle sendPacketWEn=1, sendPacketPID=5, -> TOKEN_WAIT, flagged SOF.
REQ-019 IDLE, transReq=1, SOFReq=0: SHALL latch transType/isoEn, clear HCStatus to 0, pulse sendPacketWEn next cycle with PID D (SETUP), 9 (IN), 1 (OUT), -> TOKEN_WAIT.
REQ-020 Every *_WAIT send state SHALL drive sendPacketWEn=0 and remain until sendPacketRdy=1.
REQ-021 TOKEN_WAIT done: SOF -> DONE; IN -> DATA_RX; SETUP/OUT -> DATA_TX.
REQ-022 DATA_TX SHALL pulse sendPacketWEn with PID 3 (SETUP, OUT_DATA0) or B (OUT_DATA1); on done -> DONE if isoEn else HS_RX.
REQ-023 HS_RX/DATA_RX SHALL pulse getPacketREn one cycle; *_RX_WAIT holds getPacketREn=0 until getPacketRdy=1.
REQ-024 On getPacketRdy SHALL copy four error flags into HCStatus[3:0].
REQ-025 HS_RX_WAIT done: RxPID 2/A/E SHALL set ACKRxed/NAKRxed/stallRxed; any other PID or any error flag sets none; -> DONE.
REQ-026 DATA_RX_WAIT done, no errors, RxPID 3 or B: SHALL set dataSequence = (RxPID==B); -> DONE if isoEn else ACK_TX.
REQ-027 DATA_RX_WAIT done, RxPID A/E, no errors: SHALL set NAKRxed/stallRxed, -> DONE, no ACK sent.
REQ-028 DATA_RX_WAIT done, any error or other PID: SHALL -> DONE without ACK.
REQ-029 ACK_TX SHALL pulse sendPacketWEn with PID 2; after sendPacketRdy -> DONE.
REQ-030 DONE SHALL pulse transDone for exactly one cycle (also for SOF), -> IDLE; HCStatus held until next transaction accept.
REQ-031 transReq/SOFReq outside IDLE SHALL be ignored (not queued); transType/isoEn changes mid-transaction SHALL have no effect.
REQ-032 Simultaneous RxTimeOut and getPacketRdy SHALL be treated as error (REQ-025/028 error path).
REQ-033 Minimum IDLE-to-IDLE for non-ISO OUT with zero-wait handshakes: accept, TOKEN pulse, wait, DATA pulse, wait, HS pulse, wait, DONE; no extra cycles.

Reset
REQ-034 rst=0 at clock edge SHALL force IDLE, including mid-transaction; no further strobes issued.
REQ-035 Reset values SHALL be: sendPacketWEn=0, sendPacketPID=0, getPacketREn=0, transDone=0, HCStatus=8'h00, busy=0, latched type/iso = 0.

Verification
REQ-036 OUT_DATA1, isoEn=0: token PID 1, data PID B, RxPID=2 no errors -> HCStatus=8'h40, one transDone.
REQ-037 IN, isoEn=0: token 9, RxPID=B no errors -> ACK PID 2 sent, HCStatus=8'h80, transDone.
REQ-038 IN, RxPID=3 with CRCError=1 -> no ACK strobe, HCStatus=8'h01; IN with RxPID=A -> HCStatus=8'h10, no ACK.
REQ-039 SOFReq=1 and transReq=1 same cycle in IDLE -> PID 5 only, transDone, then transReq must be re-asserted to start.
REQ-040 SETUP, isoEn=1: token D, data 3, no getPacketREn, transDone, HCStatus=8'h00; rst=0 during DATA_TX_WAIT -> IDLE, all outputs 0.
